capture_scheduler: RTL

CAPTURE_SCHEDULER -- requirements
Module: capture_scheduler

---
 rtl/rofofo_pkg.sv | 16 +
 rtl/capture_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rofofo_pkg.sv
// Shared types for the capture path: FSM state encoding and overrun counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rofofo_pkg;

   // Capture scheduler FSM states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SEND    = 2'd2
   } state_e;

   // Width of the saturating dropped-sample counter.
   localparam int OVR_W = 16;

endpackage

// File: rtl/capture_scheduler.sv
// Decimates I2S samples, keeps the top NBYTES bytes of each and serialises them MSB-first into a byte FIFO.
// Latency: first byte is written the cycle after the kept sample_valid, then one byte per cycle.
// Backpressure: fifo_full stalls the serializer in place; samples arriving while sending are dropped and counted.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   start, stop         single-cycle control pulses (arm / end capture)
//   decim, frame_len    keep 1 of decim+1 samples; samples per frame (0 = continuous), latched on start
//   sample_valid/_data  sample strobe and signed sample from the I2S receiver
//   fifo_full           FIFO write-side full flag
//   fifo_wr_en/_data    FIFO byte write port
//   capturing           high while armed (CAPTURE or SEND)
//   done                one-cycle pulse when a frame completes or a stop takes effect
//   overrun_count       samples dropped since start, saturating
module capture_scheduler
   import rofofo_pkg::*;
#(
   parameter int DATA_SIZE     = 24,
   parameter int REDUCE_FACTOR = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic [3:0]           decim,
   input  logic [15:0]          frame_len,
   input  logic                 sample_valid,
   input  logic [DATA_SIZE-1:0] sample_data,
   input  logic                 fifo_full,
   output logic                 fifo_wr_en,
   output logic [7:0]           fifo_wr_data,
   output logic                 capturing,
   output logic                 done,
   output logic [OVR_W-1:0]     overrun_count
);

   localparam int NBYTES = DATA_SIZE / 8 - REDUCE_FACTOR;
   localparam int SW     = 8 * NBYTES;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

   state_e               state_q, state_d;
   logic [3:0]           decim_q, decim_d;
   logic [15:0]          frame_len_q, frame_len_d;
   logic [3:0]           dec_cnt_q, dec_cnt_d;
   logic [15:0]          smp_cnt_q, smp_cnt_d;
   logic [SW-1:0]        shift_q, shift_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 stop_pend_q, stop_pend_d;
   logic [OVR_W-1:0]     overrun_q, overrun_d;
   logic                 done_q, done_d;

   logic [SW-1:0]        sample_top;
   logic [3:0]           dec_next;
   logic [15:0]          smp_inc;
   logic                 frame_end;

   // Discarded LSB bytes fall off the shift; the cast keeps the retained MSB bytes.
   assign sample_top = SW'(sample_data >> (8 * REDUCE_FACTOR));
   assign dec_next   = (dec_cnt_q == decim_q) ? 4'd0 : dec_cnt_q + 4'd1;
   assign smp_inc    = smp_cnt_q + 16'd1;
   assign frame_end  = (frame_len_q != 16'd0) && (smp_inc == frame_len_q);

   always_comb begin
      state_d     = state_q;
      decim_d     = decim_q;
      frame_len_d = frame_len_q;
      dec_cnt_d   = dec_cnt_q;
      smp_cnt_d   = smp_cnt_q;
      shift_d     = shift_q;
      idx_d       = idx_q;
      stop_pend_d = stop_pend_q;
      overrun_d   = overrun_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            // stop beats a coincident start
            if (start && !stop) begin
               state_d     = CAPTURE;
               decim_d     = decim;
               frame_len_d = frame_len;
               dec_cnt_d   = 4'd0;
               smp_cnt_d   = 16'd0;
               overrun_d   = '0;
               stop_pend_d = 1'b0;
               idx_d       = '0;
            end
         end

         CAPTURE: begin
            if (stop) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (sample_valid) begin
               dec_cnt_d = dec_next;
               if (dec_cnt_q == 4'd0) begin
                  shift_d = sample_top;
                  idx_d   = '0;
                  state_d = SEND;
               end
            end
         end

         SEND: begin
            if (stop) begin
               stop_pend_d = 1'b1;
            end
            // A busy serializer drops the sample but still counts it against decimation.
            if (sample_valid) begin
               dec_cnt_d = dec_next;
               if (overrun_q != {OVR_W{1'b1}}) begin
                  overrun_d = overrun_q + 1'b1;
               end
            end
            if (!fifo_full) begin
               shift_d = shift_q << 8;
               idx_d   = idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
                  idx_d     = '0;
                  smp_cnt_d = smp_inc;
                  // A stop landing on the final byte merges with frame completion: one done.
                  if (stop_pend_q || stop || frame_end) begin
                     state_d     = IDLE;
                     done_d      = 1'b1;
                     stop_pend_d = 1'b0;
                  end else begin
                     state_d = CAPTURE;
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         decim_q     <= 4'd0;
         frame_len_q <= 16'd0;
         dec_cnt_q   <= 4'd0;
         smp_cnt_q   <= 16'd0;
         shift_q     <= '0;
         idx_q       <= '0;
         stop_pend_q <= 1'b0;
         overrun_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         decim_q     <= decim_d;
         frame_len_q <= frame_len_d;
         dec_cnt_q   <= dec_cnt_d;
         smp_cnt_q   <= smp_cnt_d;
         shift_q     <= shift_d;
         idx_q       <= idx_d;
         stop_pend_q <= stop_pend_d;
         overrun_q   <= overrun_d;
         done_q      <= done_d;
      end
   end

   // Write port is combinational from state so the first byte goes out the cycle after the kept sample.
   assign fifo_wr_en    = (state_q == SEND) && !fifo_full;
   assign fifo_wr_data  = (state_q == SEND) ? shift_q[SW-1 -: 8] : 8'h00;
   assign capturing     = (state_q != IDLE);
   assign done          = done_q;
   assign overrun_count = overrun_q;

endmodule
